alm_soa: RTL and testbench

//  Approximate logarithmic multiplier (Mitchell ALM) using a set-one adder (SOA) for the log-fraction sum.

---
 rtl/alm_soa.sv | 86 ++++++++
 tb/tb_alm_soa.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alm_soa.sv
// Approximate Mitchell logarithmic multiplier whose log-fraction adder forces the low M sum bits to one.
// Latency: 1 cycle from in_valid to out_valid. A new operand pair is accepted every cycle.
// Backpressure: none. p holds its last value while in_valid is low.
//
// Ports:
//   clk, rst_n      clock and async active-low reset (clears p and out_valid at once)
//   in_valid, x, y  unsigned N-bit operands, sampled on the rising edge when in_valid=1
//   out_valid, p    registered (2N-1)-bit approximate product
// Optional feature: define ALM_SOA_SAT_EN to clamp overflowing results to all ones.
// Without it, overflowing results wrap modulo 2^(2N-1).
module alm_soa #(
  parameter int N = 9,
  parameter int M = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     y,
  output logic             out_valid,
  output logic [2*N-2:0]   p
);

  localparam int F  = N - 1;          // fraction width
  localparam int PW = 2 * N - 1;      // product width
  localparam int KW = $clog2(N);      // leading-one position width
  localparam int SW = $clog2(2 * N);  // holds k1+k2+c (max 2N-1)
  localparam int W  = F + 2 * N;      // {1,s} shifted by up to 2N-1, no bits lost

  localparam logic [F-1:0] LO_MASK = F'((1 << M) - 1);
  localparam logic [F-1:0] HI_MASK = ~LO_MASK;

  // Position of the highest set bit; 0 for a zero input (zero is handled separately).
  function automatic logic [KW-1:0] lod(input logic [N-1:0] v);
    logic [KW-1:0] pos;
    pos = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) pos = KW'(i);
    end
    return pos;
  endfunction

  logic [KW-1:0] k1, k2;
  logic [N-1:0]  xn, yn;
  logic [F-1:0]  f1, f2, s;
  logic [F:0]    hsum;
  logic          c;
  logic [SW-1:0] sh;
  logic [W-1:0]  shifted;
  logic [PW-1:0] res;

  always_comb begin
    k1 = lod(x);
    k2 = lod(y);
    // Normalize so the leading one lands on bit F; the bits below it are the fraction.
    xn = x << (KW'(F) - k1);
    yn = y << (KW'(F) - k2);
    f1 = xn[F-1:0];
    f2 = yn[F-1:0];
    // Only the upper F-M fraction bits are added. Masked low bits are zero, so
    // no carry can come up from them; they are then forced to one.
    hsum = {1'b0, f1 & HI_MASK} + {1'b0, f2 & HI_MASK};
    c    = hsum[F];
    s    = hsum[F-1:0] | LO_MASK;
    // Antilog: 1.s scaled by 2^(k1+k2+c). The result is then truncated by F bits.
    sh      = SW'(k1) + SW'(k2) + SW'(c);
    shifted = W'({1'b1, s}) << sh;
`ifdef ALM_SOA_SAT_EN
    res = ((shifted >> F) >= W'(1 << PW)) ? '1 : PW'(shifted >> F);
`else
    res = PW'(shifted >> F);
`endif
    if (x == '0 || y == '0) res = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p         <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) p <= res;
    end
  end

endmodule

// File: tb/tb_alm_soa.sv
// Self-checking bench for alm_soa (N=9, M=6): directed cases, a reset check, a streaming check and a random sweep.
// The reference model computes f(x,y) with integer arithmetic from the log-domain definition.
// The bench also reports accuracy metrics over the sweep.
module tb_alm_soa;

  localparam int N  = 9;
  localparam int M  = 6;
  localparam int F  = N - 1;
  localparam int PW = 2 * N - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  x = '0;
  logic [N-1:0]  y = '0;
  logic          out_valid;
  logic [PW-1:0] p;

  int n_checks = 0;
  int n_fails  = 0;

  alm_soa #(.N(N), .M(M)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y),
    .out_valid(out_valid), .p(p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: leading-one exponents, fractions, an SOA sum on the top F-M bits, then the antilog.
  function automatic longint ref_f(input longint a, input longint b);
    longint k1, k2, f1, f2, hi, c, s, r;
    if (a == 0 || b == 0) return 0;
    k1 = 0; while ((a >> (k1 + 1)) != 0) k1++;
    k2 = 0; while ((b >> (k2 + 1)) != 0) k2++;
    f1 = (a << (F - k1)) % (64'd1 << F);
    f2 = (b << (F - k2)) % (64'd1 << F);
    hi = (f1 >> M) + (f2 >> M);
    c  = hi >> (F - M);
    s  = ((hi % (64'd1 << (F - M))) << M) + ((64'd1 << M) - 1);
    r  = (((64'd1 << F) + s) << (k1 + k2 + c)) >> F;
`ifdef ALM_SOA_SAT_EN
    if (r >= (64'd1 << PW)) r = (64'd1 << PW) - 1;
`else
    r = r % (64'd1 << PW);
`endif
    return r;
  endfunction

  // Single operation: drive on a falling edge; the result is checked one cycle later on the falling edge.
  task automatic do_op(input string tag, input int a, input int b, input longint exp);
    @(negedge clk);
    x = N'(a); y = N'(b); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_vld"}, out_valid, 1);
    check(tag, p, exp);
  endtask

  initial begin
    int xs[4], ys[4];
    longint last_p, exp_p;
    bit prev_v;
    int prev_x, prev_y;
    real sum_ed, sum_red, max_ed;
    int n_sw, n_nz;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_vld", out_valid, 0);
    check("rst_p", p, 0);
    rst_n = 1'b1;

    // Directed cases
    do_op("zero_x", 0, 200, 0);
    do_op("zero_y", 77, 0, 0);
    do_op("128x64", 128, 64, 10208);
    do_op("1x1", 1, 1, 1);
    do_op("3x5", 3, 5, 15);
    do_op("255x255", 255, 255, 57216);
`ifdef ALM_SOA_SAT_EN
    do_op("511x511", 511, 511, 131071);
`else
    do_op("511x511", 511, 511, 97792);
`endif
    do_op("511x511_model", 511, 511, ref_f(511, 511));

    // Back-to-back stream of four operations
    xs = '{17, 255, 100, 3};
    ys = '{33, 2, 100, 5};
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      x = N'(xs[i]); y = N'(ys[i]); in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("stream%0d_vld", i), out_valid, 1);
      check($sformatf("stream%0d", i), p, ref_f(xs[i], ys[i]));
    end
    in_valid = 1'b0;
    x = 9'd400; y = 9'd400;
    last_p = ref_f(xs[3], ys[3]);
    @(negedge clk);
    check("idle_vld", out_valid, 0);
    check("idle_hold", p, last_p);
    @(negedge clk);
    check("idle_hold2", p, last_p);

    // Async reset between edges, with an operation in flight
    x = 9'd255; y = 9'd255; in_valid = 1'b1;
    @(posedge clk); #2;
    check("pre_rst_p", p, 57216);
    x = 9'd100; y = 9'd100;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_vld", out_valid, 0);
    check("async_rst_p", p, 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_hold_p", p, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_vld", out_valid, 0);
    do_op("post_rst_3x5", 3, 5, 15);

    // Random sweep with random valid gaps, checked one cycle behind
    sum_ed = 0.0; sum_red = 0.0; max_ed = 0.0; n_sw = 0; n_nz = 0;
    exp_p = 15;
    prev_v = 1'b0; prev_x = 0; prev_y = 0;
    for (int i = 0; i < 1500; i++) begin
      int a, b;
      a = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(0, 255);
      b = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(0, 255);
      x = N'(a); y = N'(b);
      in_valid = ($urandom_range(0, 3) != 0);
      prev_v = in_valid; prev_x = a; prev_y = b;
      @(negedge clk);
      if (prev_v) begin
        real ed, exact;
        exp_p = ref_f(prev_x, prev_y);
        exact = real'(prev_x * prev_y);
        ed = (real'(exp_p) > exact) ? real'(exp_p) - exact : exact - real'(exp_p);
        sum_ed += ed;
        if (ed > max_ed) max_ed = ed;
        if (prev_x * prev_y != 0) begin
          sum_red += ed / exact;
          n_nz++;
        end
        n_sw++;
      end
      check("sweep_vld", out_valid, prev_v);
      check("sweep_p", p, exp_p);
    end
    in_valid = 1'b0;

    if (n_sw > 0 && n_nz > 0)
      $display("Accuracy (0..255): MED=%0.3f MRED=%0.5f NMED=%0.6f max_err=%0.0f over %0d products",
               sum_ed / n_sw, sum_red / n_nz, (sum_ed / n_sw) / (255.0 * 255.0), max_ed, n_sw);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
